// File: rtl/stack_arbiter_ctrl.sv
// Two-port arbiter and byte sequencer for the 8-bit hardware stack.
// Splits 16-bit pushes/pops into byte strobes and tracks occupancy for bound checks.
module stack_arbiter_ctrl #(
    parameter int DEPTH = 32,
    parameter int CW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          a_req,
    input  logic [1:0]    a_op,
    input  logic [15:0]   a_wdata,
    output logic          a_ack,
    input  logic          b_req,
    input  logic [1:0]    b_op,
    input  logic [15:0]   b_wdata,
    output logic          b_ack,
    output logic [15:0]   rdata,
    output logic          err,
    output logic          stk_push,
    output logic          stk_pop,
    output logic          stk_clr,
    output logic [7:0]    stk_din,
    input  logic [7:0]    stk_dout,
    output logic [CW-1:0] count,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE, PUSH_HI, PUSH_LO, POP_A, POP_B, CAP, CAP_HI, ACK
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          id_q, id_d;
    logic          last_b_q, last_b_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          a_ack_q, a_ack_d;
    logic          b_ack_q, b_ack_d;
    logic          stk_push_q, stk_push_d;
    logic          stk_pop_q, stk_pop_d;
    logic [7:0]    stk_din_q, stk_din_d;

    logic          flush_clr;
    logic          grant_b;
    logic [1:0]    sel_op;
    logic [15:0]   sel_wdata;
    logic [CW:0]   count_ext;
    logic [CW:0]   need;
    logic          bound_bad;

    // Round-robin: on a tie, B wins only if A was granted last.
    assign grant_b   = b_req & (~a_req | ~last_b_q);
    assign sel_op    = grant_b ? b_op : a_op;
    assign sel_wdata = grant_b ? b_wdata : a_wdata;
    assign count_ext = {1'b0, count_q};
    assign need      = sel_op[1] ? (CW+1)'(2) : (CW+1)'(1);
    assign bound_bad = sel_op[0] ? (count_ext < need)
                                 : (count_ext + need > (CW+1)'(DEPTH));

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wdata_d    = wdata_q;
        id_d       = id_q;
        last_b_d   = last_b_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        stk_push_d = 1'b0;
        stk_pop_d  = 1'b0;
        stk_din_d  = stk_din_q;
        flush_clr  = 1'b0;

        // Occupancy follows the strobes actually issued to the stack.
        count_d = count_q;
        if (stk_push_q) begin
            count_d = count_q + CW'(1);
        end else if (stk_pop_q) begin
            count_d = count_q - CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (flush) begin
                    flush_clr = 1'b1;
                    count_d   = '0;
                end else if (a_req || b_req) begin
                    op_d     = sel_op;
                    wdata_d  = sel_wdata;
                    id_d     = grant_b;
                    last_b_d = grant_b;
                    err_d    = bound_bad;
                    if (bound_bad) begin
                        state_d = ACK;
                        a_ack_d = ~grant_b;
                        b_ack_d = grant_b;
                    end else begin
                        case (sel_op)
                            2'b10: begin
                                state_d    = PUSH_HI;
                                stk_push_d = 1'b1;
                                stk_din_d  = sel_wdata[15:8];
                            end
                            2'b00: begin
                                state_d    = PUSH_LO;
                                stk_push_d = 1'b1;
                                stk_din_d  = sel_wdata[7:0];
                            end
                            default: begin
                                state_d   = POP_A;
                                stk_pop_d = 1'b1;
                            end
                        endcase
                    end
                end
            end
            PUSH_HI: begin
                state_d    = PUSH_LO;
                stk_push_d = 1'b1;
                stk_din_d  = wdata_q[7:0];
            end
            PUSH_LO: begin
                state_d = ACK;
                a_ack_d = ~id_q;
                b_ack_d = id_q;
            end
            POP_A: begin
                if (op_q[1]) begin
                    state_d   = POP_B;
                    stk_pop_d = 1'b1;
                end else begin
                    state_d = CAP;
                end
            end
            POP_B: begin
                rdata_d = {rdata_q[15:8], stk_dout};
                state_d = CAP_HI;
            end
            CAP: begin
                rdata_d = {8'h00, stk_dout};
                state_d = ACK;
                a_ack_d = ~id_q;
                b_ack_d = id_q;
            end
            CAP_HI: begin
                rdata_d = {stk_dout, rdata_q[7:0]};
                state_d = ACK;
                a_ack_d = ~id_q;
                b_ack_d = id_q;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_b_q   <= 1'b1;
            count_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            stk_push_q <= 1'b0;
            stk_pop_q  <= 1'b0;
            stk_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            count_q    <= count_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            stk_push_q <= stk_push_d;
            stk_pop_q  <= stk_pop_d;
            stk_din_q  <= stk_din_d;
        end
    end

    // Latched request fields are only consumed after a grant, so they need no reset.
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        wdata_q <= wdata_d;
        id_q    <= id_d;
    end

    assign stk_clr  = ~rst_n | flush_clr;
    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign rdata    = rdata_q;
    assign err      = err_q;
    assign stk_push = stk_push_q;
    assign stk_pop  = stk_pop_q;
    assign stk_din  = stk_din_q;
    assign count    = count_q;
    assign busy     = (state_q != IDLE);

endmodule
